// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared FSM state, next-PC select codes and PC constants for pc_gen
package pc_gen_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      SEL_HOLD     = 3'd0,
      SEL_ADVANCE  = 3'd1,
      SEL_STALL    = 3'd2,
      SEL_REDIRECT = 3'd3,
      SEL_TRAP     = 3'd4
   } sel_t;

   localparam int unsigned PC_STEP           = 4;
   localparam logic [63:0] DEFAULT_RESET_VEC = 64'h0;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational next-PC mux: trap > redirect > stall > advance > hold
module pc_next_sel
   import pc_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] pc,
   input  logic            stall,
   input  logic            advance,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_vec,
   output logic [XLEN-1:0] next_pc,
   output sel_t            sel
);

   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   always_comb begin
      next_pc = pc;
      sel     = SEL_HOLD;
      if (trap_valid) begin
         next_pc = trap_vec & ALIGN_MASK;
         sel     = SEL_TRAP;
      end else if (redirect_valid) begin
         next_pc = redirect_pc & ALIGN_MASK;
         sel     = SEL_REDIRECT;
      end else if (stall) begin
         sel     = SEL_STALL;
      end else if (advance) begin
         next_pc = pc + XLEN'(PC_STEP);
         sel     = SEL_ADVANCE;
      end
   end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC generator with BOOT/RUN/HALT FSM; PC_GEN_TRAP_EN adds trap inputs
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEFAULT_RESET_VEC)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_i,
   input  logic            halt_i,
   input  logic            redirect_valid_i,
   input  logic [XLEN-1:0] redirect_pc_i,
`ifdef PC_GEN_TRAP_EN
   input  logic            trap_valid_i,
   input  logic [XLEN-1:0] trap_vec_i,
`endif
   input  logic            req_ready_i,
   output logic            req_valid_o,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc_plus4_o,
   output logic            epoch_o,
   output logic            misalign_o
);

   state_t          state;
   sel_t            sel;
   logic [XLEN-1:0] next_pc;
   logic            trap_v;
   logic [XLEN-1:0] trap_pc;
   logic            advance;
   logic            retarget;

`ifdef PC_GEN_TRAP_EN
   assign trap_v  = trap_valid_i;
   assign trap_pc = trap_vec_i;
`else
   assign trap_v  = 1'b0;
   assign trap_pc = '0;
`endif

   assign req_valid_o = (state == ST_RUN) && !stall_i;
   assign advance     = req_valid_o && req_ready_i;
   assign retarget    = (sel == SEL_REDIRECT) || (sel == SEL_TRAP);
   assign pc_plus4_o  = pc_o + XLEN'(PC_STEP);

   pc_next_sel #(.XLEN(XLEN)) u_next_sel (
      .pc             (pc_o),
      .stall          (stall_i),
      .advance        (advance),
      .redirect_valid (redirect_valid_i),
      .redirect_pc    (redirect_pc_i),
      .trap_valid     (trap_v),
      .trap_vec       (trap_pc),
      .next_pc        (next_pc),
      .sel            (sel)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_BOOT;
         pc_o       <= RESET_VEC;
         epoch_o    <= 1'b0;
         misalign_o <= 1'b0;
      end else begin
         pc_o       <= next_pc;
         misalign_o <= (sel == SEL_REDIRECT) && (redirect_pc_i[1:0] != 2'b00);
         if (retarget) begin
            epoch_o <= ~epoch_o;
         end
         // halt_i is sticky: a same-cycle retarget loads the PC but stays halted
         case (state)
            ST_BOOT: state <= ST_RUN;
            ST_RUN:  if (halt_i) state <= ST_HALT;
            ST_HALT: if (!halt_i && retarget) state <= ST_RUN;
            default: state <= ST_BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - scoreboard bench for pc_gen; trap vectors run when PC_GEN_TRAP_EN is defined
module tb_pc_gen;

   typedef struct {
      string       name;
      logic        valid;
      logic [31:0] pc;
      logic        epoch;
      logic        mis;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_i, halt_i, redirect_valid_i, req_ready_i;
   logic [31:0] redirect_pc_i;
   logic        req_valid_o, epoch_o, misalign_o;
   logic [31:0] pc_o, pc_plus4_o;
`ifdef PC_GEN_TRAP_EN
   logic        trap_valid_i;
   logic [31:0] trap_vec_i;
   logic        pend_trap = 1'b0;
   logic [31:0] pend_vec  = '0;
`endif

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pc_gen #(.XLEN(32), .RESET_VEC(32'h100)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .stall_i          (stall_i),
      .halt_i           (halt_i),
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i),
`ifdef PC_GEN_TRAP_EN
      .trap_valid_i     (trap_valid_i),
      .trap_vec_i       (trap_vec_i),
`endif
      .req_ready_i      (req_ready_i),
      .req_valid_o      (req_valid_o),
      .pc_o             (pc_o),
      .pc_plus4_o       (pc_plus4_o),
      .epoch_o          (epoch_o),
      .misalign_o       (misalign_o)
   );

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h expected %h", n, got, want);
      end
   endtask

   // apply one cycle of inputs just after the edge and queue the outputs expected in that cycle
   task automatic cyc(input logic rst, input logic st, input logic hl, input logic rv,
                      input logic [31:0] rpc, input logic rdy, input string name,
                      input logic ev, input logic [31:0] epc, input logic ee, input logic em);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n            = rst;
      stall_i          = st;
      halt_i           = hl;
      redirect_valid_i = rv;
      redirect_pc_i    = rpc;
      req_ready_i      = rdy;
`ifdef PC_GEN_TRAP_EN
      trap_valid_i = pend_trap;
      trap_vec_i   = pend_vec;
      pend_trap    = 1'b0;
`endif
      e.name  = name;
      e.valid = ev;
      e.pc    = epc;
      e.epoch = ee;
      e.mis   = em;
      q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.name, ".valid"}, {31'd0, req_valid_o}, {31'd0, e.valid});
            chk({e.name, ".pc"}, pc_o, e.pc);
            chk({e.name, ".pc4"}, pc_plus4_o, e.pc + 32'd4);
            chk({e.name, ".epoch"}, {31'd0, epoch_o}, {31'd0, e.epoch});
            chk({e.name, ".mis"}, {31'd0, misalign_o}, {31'd0, e.mis});
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      rst_n = 1'b0; stall_i = 1'b0; halt_i = 1'b0; redirect_valid_i = 1'b0;
      redirect_pc_i = '0; req_ready_i = 1'b1;
`ifdef PC_GEN_TRAP_EN
      trap_valid_i = 1'b0; trap_vec_i = '0;
`endif
      //   rst st hl rv rpc            rdy name         valid pc            ep mis
      cyc(0, 0, 0, 0, 32'h0,        1, "reset",      0, 32'h100,      0, 0);
      cyc(1, 0, 0, 0, 32'h0,        1, "boot",       0, 32'h100,      0, 0);
      cyc(1, 0, 0, 0, 32'h0,        1, "run0",       1, 32'h100,      0, 0);
      cyc(1, 0, 0, 0, 32'h0,        1, "run1",       1, 32'h104,      0, 0);
      cyc(1, 0, 0, 1, 32'h200,      1, "run2_rd",    1, 32'h108,      0, 0);
      cyc(1, 0, 0, 0, 32'h0,        0, "wait0",      1, 32'h200,      1, 0);
      cyc(1, 0, 0, 0, 32'h0,        0, "wait1",      1, 32'h200,      1, 0);
      cyc(1, 0, 0, 0, 32'h0,        0, "wait2",      1, 32'h200,      1, 0);
      cyc(1, 0, 0, 0, 32'h0,        1, "accept",     1, 32'h200,      1, 0);
      cyc(1, 1, 0, 1, 32'h403,      1, "stall_rd",   0, 32'h204,      1, 0);
      cyc(1, 1, 0, 0, 32'h0,        1, "misalign",   0, 32'h400,      0, 1);
      cyc(1, 0, 0, 1, 32'hFFFFFFFC, 1, "unstall",    1, 32'h400,      0, 0);
      cyc(1, 0, 0, 0, 32'h0,        1, "top",        1, 32'hFFFFFFFC, 1, 0);
      cyc(1, 0, 1, 0, 32'h0,        0, "wrap_halt",  1, 32'h0,        1, 0);
      cyc(1, 0, 0, 0, 32'h0,        1, "halted",     0, 32'h0,        1, 0);
      cyc(1, 0, 0, 1, 32'h800,      1, "halt_rd",    0, 32'h0,        1, 0);
      cyc(1, 0, 0, 0, 32'h0,        1, "resume",     1, 32'h800,      0, 0);
      cyc(1, 0, 1, 0, 32'h0,        0, "halt2",      1, 32'h804,      0, 0);
      cyc(1, 0, 1, 1, 32'h900,      1, "halt_and_rd",0, 32'h804,      0, 0);
      cyc(1, 0, 0, 0, 32'h0,        1, "still_halt", 0, 32'h900,      1, 0);
      cyc(1, 0, 0, 1, 32'hA00,      1, "halt_rd2",   0, 32'h900,      1, 0);
      cyc(1, 0, 0, 0, 32'h0,        1, "run_a00",    1, 32'hA00,      0, 0);
      cyc(1, 0, 0, 0, 32'h0,        1, "run_a04",    1, 32'hA04,      0, 0);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      cyc(0, 0, 0, 0, 32'h0,        1, "rst_mid",    0, 32'h100,      0, 0);
      cyc(1, 0, 0, 0, 32'h0,        1, "boot2",      0, 32'h100,      0, 0);
      cyc(1, 0, 0, 0, 32'h0,        1, "rerun0",     1, 32'h100,      0, 0);
      cyc(1, 0, 0, 0, 32'h0,        1, "rerun1",     1, 32'h104,      0, 0);
`ifdef PC_GEN_TRAP_EN
      pend_trap = 1'b1;
      pend_vec  = 32'h1001;
      cyc(1, 0, 0, 1, 32'h2002,     1, "trap_rd",    1, 32'h108,      0, 0);
      cyc(1, 0, 0, 0, 32'h0,        1, "trap_pc",    1, 32'h1000,     1, 0);
      cyc(1, 0, 0, 0, 32'h0,        1, "trap_adv",   1, 32'h1004,     1, 0);
`else
      cyc(1, 0, 0, 0, 32'h0,        1, "rerun2",     1, 32'h108,      0, 0);
`endif
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain queue still holds %0d entries, expected 0", q.size());
      end
      @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL provide parameter XLEN, default 32, PC width in bits (legal: 32 or 64).
REQ-002 SHALL provide parameter RESET_VEC, default 0, XLEN-bit boot address (bits [1:0] SHALL be 0).
REQ-003 SHALL have one clock; reset is asynchronous and active-low: port clk input 1, rising-edge clock.
REQ-004 rst_n input 1: asynchronous active-low reset.
REQ-005 stall_i input 1: fetch stage stalled; hold PC and drop request.
REQ-006 halt_i input 1: enter HALT state (sticky).
REQ-007 redirect_valid_i input 1: branch/jump redirect this cycle.
REQ-008 redirect_pc_i input XLEN: redirect target.
REQ-009 req_ready_i input 1: instruction memory accepts request.
REQ-010 req_valid_o output 1: fetch request valid.
REQ-011 pc_o output XLEN: registered fetch PC.
REQ-012 pc_plus4_o output XLEN: pc_o + 4, modulo 2^XLEN.
REQ-013 epoch_o output 1: fetch epoch, toggles on every accepted redirect or trap.
REQ-014 misalign_o output 1: one-cycle registered pulse when a redirect target had bits [1:0] nonzero.

Function
REQ-015 SHALL implement FSM states BOOT, RUN, HALT, encoded as a shared enum.
REQ-016 BOOT SHALL last exactly one cycle after reset release with req_valid_o=0, then go to RUN.
REQ-017 In RUN, req_valid_o SHALL equal !stall_i; in BOOT and HALT it SHALL be 0.
REQ-018 Next-PC priority SHALL be trap (if compiled) > redirect > stall > advance > hold.
REQ-019 Advance: when req_valid_o && req_ready_i, pc_o SHALL become pc_o+4 next cycle; 2^XLEN-4 wraps to 0.
REQ-020 While req_valid_o && !req_ready_i with no redirect/trap, pc_o SHALL remain stable.
REQ-021 Redirect SHALL load redirect_pc_i with bits [1:0] forced to 0 next cycle, in any state, including during stall or an unaccepted request.
REQ-022 Redirect SHALL toggle epoch_o next cycle; misalign_o SHALL pulse when redirect_pc_i[1:0]!=0.
REQ-023 Redirect in HALT SHALL return FSM to RUN; halt_i with redirect in the same cycle SHALL leave FSM in HALT with the new PC loaded.
REQ-024 Stall SHALL freeze pc_o and epoch_o, but never suppress redirect or trap.
REQ-025 halt_i in RUN SHALL enter HALT next cycle; pc_o holds.
REQ-026 pc_o, epoch_o and misalign_o SHALL change only on clk rising edge, except under reset.

Reset
REQ-027 rst_n low SHALL immediately force state BOOT, pc_o=RESET_VEC, epoch_o=0, misalign_o=0, req_valid_o=0.
REQ-028 Reset asserted mid-request SHALL abort it; no advance occurs on the release edge.

Configuration
REQ-029 Macro PC_GEN_TRAP_EN SHALL add inputs trap_valid_i (1) and trap_vec_i (XLEN).
REQ-030 With PC_GEN_TRAP_EN, trap SHALL load trap_vec_i & ~3, toggle epoch_o, return to RUN from HALT, and override a simultaneous redirect (misalign_o not pulsed).
REQ-031 Without PC_GEN_TRAP_EN, those ports SHALL not exist and behaviour is REQ-015..028 unchanged.

Structure
REQ-032 pc_gen_pkg SHALL hold the FSM state enum, the PC_STEP constant (4), and the default reset vector.
REQ-033 One combinational sub-module pc_next_sel SHALL compute next PC and select per REQ-018.

Verification
REQ-034 Reset release, RESET_VEC=0x100, ready=1 -> BOOT 1 cycle, then pc_o 0x100, 0x104, 0x108.
REQ-035 ready=0 for 3 cycles at pc 0x200 -> pc_o stays 0x200, req_valid_o=1; advances to 0x204 after ready.
REQ-036 stall_i=1 with redirect to 0x403 -> pc_o=0x400, epoch toggles, misalign_o pulses 1 cycle, req_valid_o=0.
REQ-037 XLEN=32, pc 0xFFFFFFFC accepted -> pc_o=0x00000000, pc_plus4_o=0x4.
REQ-038 halt_i then redirect to 0x800 -> HALT with req_valid_o=0, then RUN at 0x800.
REQ-039 PC_GEN_TRAP_EN, trap 0x1000 and redirect 0x2000 same cycle -> pc_o=0x1000, single epoch toggle.
